mux_rr_arbiter: RTL



---
 rtl/mux_arb_pkg.sv | 39 +++
 rtl/mux_nto1.sv | 24 ++
 rtl/mux_rr_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared arbitration types and the round-robin pick helper.
// Reusable by any arbiter with up to RR_MAX requesters.
package mux_arb_pkg;

  localparam int RR_MAX = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First set bit scanning start, start+1, ... modulo n.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX-1:0] req,
    input int                n,
    input int                start
  );
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (i < n) begin
        k = start + i;
        if (k >= n) k = k - n;
        if (req[k[4:0]]) begin
          r.found = 1'b1;
          r.idx   = k[4:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// Parameterised N-to-1 word select, zero when not enabled.
module mux_nto1 #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ*DATA_W-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  output logic [DATA_W-1:0]       y
);

  logic [DATA_W-1:0] words [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_w
    assign words[k] = data[k*DATA_W +: DATA_W];
  end

  always_comb begin
    y = '0;
    if (en) y = words[sel];
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded hold time driving a shared N-to-1 mux.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*DATA_W-1:0]  data_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] sel_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o
);

  localparam int SW = $clog2(N_REQ);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);
  localparam logic [SW-1:0] LAST = SW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  arb_state_t state, state_n;
  logic [SW-1:0] ptr, ptr_n, sel_n, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] gnt_n, others;
  logic valid_n;
  logic [RR_MAX-1:0] req_ext;
  rr_pick_t pick_ptr, pick_nxt;

  assign req_ext  = RR_MAX'(req_i);
  assign nxt      = (sel_o == LAST) ? '0 : sel_o + 1'b1;
  assign others   = req_i & ~(ONE << sel_o);
  assign pick_ptr = rr_pick(req_ext, N_REQ, int'(ptr));
  assign pick_nxt = rr_pick(req_ext, N_REQ, int'(nxt));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    sel_n   = sel_o;
    gnt_n   = gnt_o;
    valid_n = valid_o;
    unique case (state)
      ARB_IDLE: begin
        if (pick_ptr.found) begin
          sel_n   = pick_ptr.idx[SW-1:0];
          gnt_n   = ONE << pick_ptr.idx[SW-1:0];
          valid_n = 1'b1;
          cnt_n   = '0;
          state_n = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!req_i[sel_o]) begin
          ptr_n = nxt;
          if (pick_nxt.found) begin
            sel_n = pick_nxt.idx[SW-1:0];
            gnt_n = ONE << pick_nxt.idx[SW-1:0];
            cnt_n = '0;
          end else begin
            gnt_n   = '0;
            valid_n = 1'b0;
            state_n = ARB_IDLE;
          end
        end else if (|others && cnt == CMAX) begin
          ptr_n = nxt;
          sel_n = pick_nxt.idx[SW-1:0];
          gnt_n = ONE << pick_nxt.idx[SW-1:0];
          cnt_n = '0;
        end else if (!(|others)) begin
          if (cnt < CMAX) cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      sel_o   <= '0;
      gnt_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      sel_o   <= sel_n;
      gnt_o   <= gnt_n;
      valid_o <= valid_n;
    end
  end

  mux_nto1 #(
    .N_REQ (N_REQ),
    .DATA_W(DATA_W),
    .SEL_W (SW)
  ) u_mux (
    .data(data_i),
    .sel (sel_o),
    .en  (valid_o),
    .y   (data_o)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, pick_ptr.idx, pick_nxt.idx};

endmodule
